rv_multicycle_ctrl: RTL and testbench

Multi-cycle sequencer for the RV32 integer datapath: fetches instructions over a valid/ready memory handshake and decodes LUI, ADDI and ANDI. It owns the PC and the 32×32 register file, and drives the external combinational ALU (a, b, opcode, funct3 → result). Each instruction is written back in its own cycle. It sits between instruction memory and the ALU and is the top-level control of the hello_asm core.

---
 rtl/rv_multicycle_ctrl.sv | 166 ++++++++++++++++
 tb/tb_rv_multicycle_ctrl.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/rv_multicycle_ctrl.sv
// Multi-cycle FETCH/DECODE/EXEC/WB sequencer for the hello_asm RV32 core.
// Owns the PC, the IR and the 32x32 register file, and drives an external combinational ALU.
module rv_multicycle_ctrl #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        reset,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic        imem_ready,
   input  logic [31:0] imem_rdata,
   output logic [31:0] alu_a,
   output logic [31:0] alu_b,
   output logic [6:0]  alu_opcode,
   output logic [2:0]  alu_funct3,
   input  logic [31:0] alu_result,
   output logic        retired,
   output logic        halted,
   output logic        illegal,
   input  logic [4:0]  dbg_addr,
   output logic [31:0] dbg_data
);

   localparam logic [6:0]  OPC_LUI    = 7'b0110111;
   localparam logic [6:0]  OPC_OP_IMM = 7'b0010011;
   localparam logic [31:0] INSN_EBREAK = 32'h0010_0073;

   typedef enum logic [2:0] {
      FETCH,
      DECODE,
      EXEC,
      WB,
      HALT
   } state_t;

   state_t      r_state;
   state_t      w_nextState;
   logic [31:0] r_pc;
   logic [31:0] r_ir;
   logic [31:0] r_result;
   logic [31:0] r_aluA;
   logic [31:0] r_aluB;
   logic [6:0]  r_aluOpcode;
   logic [2:0]  r_aluFunct3;
   logic        r_illegal;
   logic [31:0] r_regs [32];

   logic [6:0]  w_opcode;
   logic [2:0]  w_funct3;
   logic [4:0]  w_rd;
   logic [4:0]  w_rs1;
   logic [31:0] w_rs1Data;
   logic        w_isLui;
   logic        w_isOpImm;
   logic        w_isEbreak;
   logic        w_legal;
   logic [31:0] w_decA;
   logic [31:0] w_decB;

   assign w_opcode   = r_ir[6:0];
   assign w_funct3   = r_ir[14:12];
   assign w_rd       = r_ir[11:7];
   assign w_rs1      = r_ir[19:15];
   assign w_rs1Data  = (w_rs1 == 5'd0) ? 32'd0 : r_regs[w_rs1];
   assign w_isLui    = (w_opcode == OPC_LUI);
   assign w_isOpImm  = (w_opcode == OPC_OP_IMM) && ((w_funct3 == 3'b000) || (w_funct3 == 3'b111));
   assign w_isEbreak = (r_ir == INSN_EBREAK);
   assign w_legal    = w_isLui || w_isOpImm;
   assign w_decA     = w_isLui ? {r_ir[31:12], 12'b0} : w_rs1Data;
   assign w_decB     = w_isLui ? 32'd0 : {{20{r_ir[31]}}, r_ir[31:20]};

   assign dbg_data = (dbg_addr == 5'd0) ? 32'd0 : r_regs[dbg_addr];

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state <= FETCH;
      end else begin
         r_state <= w_nextState;
      end
   end

   // Outputs are forced inactive while reset is asserted so a mid-instruction reset
   // never shows a retire, a fetch or a live ALU operand.
   always_comb begin
      w_nextState = r_state;
      imem_req    = 1'b0;
      retired     = 1'b0;
      halted      = 1'b0;
      imem_addr   = r_pc;
      alu_a       = reset ? 32'd0 : r_aluA;
      alu_b       = reset ? 32'd0 : r_aluB;
      alu_opcode  = reset ? 7'd0  : r_aluOpcode;
      alu_funct3  = reset ? 3'd0  : r_aluFunct3;
      illegal     = r_illegal && !reset;
      case (r_state)
         FETCH: begin
            imem_req = !reset;
            if (imem_ready) begin
               w_nextState = DECODE;
            end
         end
         DECODE: begin
            w_nextState = w_legal ? EXEC : HALT;
         end
         EXEC: begin
            w_nextState = WB;
         end
         WB: begin
            retired     = !reset;
            w_nextState = FETCH;
         end
         HALT: begin
            halted = !reset;
         end
         default: begin
            w_nextState = FETCH;
         end
      endcase
   end

   // ALU operand registers are loaded only on the DECODE->EXEC edge and cleared otherwise,
   // so they are non-zero exactly during EXEC.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_pc        <= RESET_PC;
         r_ir        <= 32'd0;
         r_result    <= 32'd0;
         r_aluA      <= 32'd0;
         r_aluB      <= 32'd0;
         r_aluOpcode <= 7'd0;
         r_aluFunct3 <= 3'd0;
         r_illegal   <= 1'b0;
         for (int i = 0; i < 32; i++) begin
            r_regs[i] <= 32'd0;
         end
      end else begin
         if (r_state == FETCH && imem_ready) begin
            r_ir <= imem_rdata;
         end
         if (r_state == DECODE && w_legal) begin
            r_aluA      <= w_decA;
            r_aluB      <= w_decB;
            r_aluOpcode <= w_opcode;
            r_aluFunct3 <= w_funct3;
         end else begin
            r_aluA      <= 32'd0;
            r_aluB      <= 32'd0;
            r_aluOpcode <= 7'd0;
            r_aluFunct3 <= 3'd0;
         end
         if (r_state == DECODE && !w_legal && !w_isEbreak) begin
            r_illegal <= 1'b1;
         end
         if (r_state == EXEC) begin
            r_result <= alu_result;
         end
         if (r_state == WB) begin
            r_pc <= r_pc + 32'd4;
            if (w_rd != 5'd0) begin
               r_regs[w_rd] <= r_result;
            end
         end
      end
   end

endmodule

// File: tb/tb_rv_multicycle_ctrl.sv
// Self-checking bench for rv_multicycle_ctrl: a memory model feeds instructions and a
// scoreboard queue of expected register writes is drained on each retired pulse.
module tb_rv_multicycle_ctrl;

   localparam logic [31:0] TB_RESET_PC = 32'hFFFF_FFF8;

   logic        clk;
   logic        reset;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_ready;
   logic [31:0] imem_rdata;
   logic [31:0] alu_a;
   logic [31:0] alu_b;
   logic [6:0]  alu_opcode;
   logic [2:0]  alu_funct3;
   logic [31:0] alu_result;
   logic        retired;
   logic        halted;
   logic        illegal;
   logic [4:0]  dbg_addr;
   logic [31:0] dbg_data;

   typedef struct {
      logic [4:0]  rd;
      logic [31:0] val;
   } sbEntry_t;

   sbEntry_t    sbQ[$];
   int          checks = 0;
   int          failures = 0;
   logic [31:0] expPc;

   rv_multicycle_ctrl #(.RESET_PC(TB_RESET_PC)) dut (
      .clk(clk),
      .reset(reset),
      .imem_req(imem_req),
      .imem_addr(imem_addr),
      .imem_ready(imem_ready),
      .imem_rdata(imem_rdata),
      .alu_a(alu_a),
      .alu_b(alu_b),
      .alu_opcode(alu_opcode),
      .alu_funct3(alu_funct3),
      .alu_result(alu_result),
      .retired(retired),
      .halted(halted),
      .illegal(illegal),
      .dbg_addr(dbg_addr),
      .dbg_data(dbg_data)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // External ALU: ANDI uses AND, everything else (ADDI, LUI with b=0) adds.
   always_comb begin
      if (alu_opcode == 7'b0010011 && alu_funct3 == 3'b111) begin
         alu_result = alu_a & alu_b;
      end else begin
         alu_result = alu_a + alu_b;
      end
   end

   task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
      checks++;
      if (actual !== expected) begin
         failures++;
         $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", tag, actual, expected);
      end
   endtask

   task automatic applyReset();
      reset = 1'b1;
      imem_ready = 1'b0;
      @(negedge clk);
      #1;
      checkOutput("rst_req", {31'd0, imem_req}, 32'd0);
      checkOutput("rst_retired", {31'd0, retired}, 32'd0);
      checkOutput("rst_halted", {31'd0, halted}, 32'd0);
      checkOutput("rst_illegal", {31'd0, illegal}, 32'd0);
      checkOutput("rst_alu_a", alu_a, 32'd0);
      @(negedge clk);
      reset = 1'b0;
      expPc = TB_RESET_PC;
      dbg_addr = 5'd1;
      #1;
      checkOutput("rst_x1", dbg_data, 32'd0);
   endtask

   task automatic waitFetch();
      int cyc;
      cyc = 0;
      while (!imem_req && cyc < 20) begin
         @(negedge clk);
         cyc++;
      end
      checkOutput("fetch_req", {31'd0, imem_req}, 32'd1);
      checkOutput("fetch_addr", imem_addr, expPc);
      checkOutput("idle_alu_a", alu_a, 32'd0);
   endtask

   task automatic applyStimulus(input logic [31:0] instr, input int stalls, input logic [4:0] rd,
                                input logic [31:0] expVal);
      int       cyc;
      bit       seen;
      sbEntry_t e;
      waitFetch();
      dbg_addr = rd;
      sbQ.push_back('{rd: rd, val: expVal});
      for (int s = 0; s < stalls; s++) begin
         imem_ready = 1'b0;
         imem_rdata = 32'hDEAD_BEEF;
         @(negedge clk);
         checkOutput("stall_req", {31'd0, imem_req}, 32'd1);
         checkOutput("stall_addr", imem_addr, expPc);
      end
      imem_ready = 1'b1;
      imem_rdata = instr;
      cyc = 0;
      seen = 1'b0;
      while (!seen && cyc < 20) begin
         @(negedge clk);
         imem_ready = 1'b0;
         cyc++;
         if (cyc == 2) begin
            checkOutput("exec_opcode", {25'd0, alu_opcode}, {25'd0, instr[6:0]});
         end
         if (retired) seen = 1'b1;
      end
      checkOutput("instr_cycles", stalls + 1 + cyc, stalls + 4);
      @(negedge clk);
      checkOutput("retire_pulse", {31'd0, retired}, 32'd0);
      if (sbQ.size() > 0) begin
         e = sbQ.pop_front();
         dbg_addr = e.rd;
         #1;
         checkOutput("wb_value", dbg_data, e.val);
      end
      expPc = expPc + 32'd4;
   endtask

   task automatic applyHalt(input logic [31:0] instr, input logic expIllegal);
      int bad;
      waitFetch();
      imem_ready = 1'b1;
      imem_rdata = instr;
      @(negedge clk);
      @(negedge clk);
      checkOutput("halt_halted", {31'd0, halted}, 32'd1);
      checkOutput("halt_illegal", {31'd0, illegal}, {31'd0, expIllegal});
      bad = 0;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (imem_req || !halted || retired || illegal !== expIllegal) bad++;
      end
      checkOutput("halt_hold", bad, 32'd0);
      imem_ready = 1'b0;
   endtask

   task automatic applyAbort();
      int bad;
      waitFetch();
      dbg_addr = 5'd1;
      imem_ready = 1'b1;
      imem_rdata = 32'h0050_0093;
      @(negedge clk);
      imem_ready = 1'b0;
      @(negedge clk);
      checkOutput("abort_in_exec", alu_b, 32'd5);
      reset = 1'b1;
      #1;
      checkOutput("abort_req", {31'd0, imem_req}, 32'd0);
      checkOutput("abort_alu_b", alu_b, 32'd0);
      bad = retired ? 1 : 0;
      @(negedge clk);
      reset = 1'b0;
      #1;
      if (retired) bad++;
      checkOutput("abort_retired", bad, 32'd0);
      checkOutput("abort_x1", dbg_data, 32'd0);
      expPc = TB_RESET_PC;
   endtask

   task automatic checkOutputSummary();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
   endtask

   initial begin
      reset = 1'b1;
      imem_ready = 1'b0;
      imem_rdata = 32'd0;
      dbg_addr = 5'd0;
      expPc = TB_RESET_PC;
      applyReset();
      applyAbort();
      applyStimulus(32'h0050_0093, 0, 5'd1, 32'd5);
      applyStimulus(32'h1234_5137, 0, 5'd2, 32'h1234_5000);
      applyStimulus(32'hFFF0_8193, 0, 5'd3, 32'd4);
      applyStimulus(32'h0060_F213, 0, 5'd4, 32'd4);
      applyStimulus(32'h00A0_8293, 3, 5'd5, 32'd15);
      applyStimulus(32'h0070_0013, 0, 5'd0, 32'd0);
      applyHalt(32'h0000_0033, 1'b1);
      applyReset();
      applyHalt(32'h0010_0073, 1'b0);
      applyReset();
      checkOutput("post_rst_halted", {31'd0, halted}, 32'd0);
      checkOutput("post_rst_illegal", {31'd0, illegal}, 32'd0);
      applyStimulus(32'h0050_0093, 0, 5'd1, 32'd5);
      waitFetch();
      checkOutput("sb_empty", sbQ.size(), 32'd0);
      checkOutputSummary();
      $finish;
   end

endmodule
